// File: rtl/uart_cmd_loader_pkg.sv
// Shared definitions for the UART command loader: host command codes and the
// decoder state encoding.
package uart_cmd_loader_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'hFF;
  localparam logic [7:0] CMD_END   = 8'hFE;
  localparam logic [7:0] CMD_WRITE = 8'h7F;
  localparam logic [7:0] CMD_TX    = 8'h7E;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/uart_cmd_loader_if.sv
// Bus bundle between the UART receiver / pixel-config shifter side and the
// command loader.
//   master : drives rx_data, rx_valid, fifo_rd_en; observes everything else
//   slave  : the loader; receives bytes and pop requests, drives status/strobes
interface uart_cmd_loader_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            fifo_rd_en;
  logic [7:0]      fifo_dout;
  logic            fifo_dvalid;
  logic            fifo_empty;
  logic            fifo_full;
  logic [ADDR_W:0] fifo_count;
  logic            loading;
  logic            write_start;
  logic            tx_start;
  logic            overflow;
  logic            bad_cmd;
  logic [7:0]      cmd;

  modport master (
    output rx_data, rx_valid, fifo_rd_en,
    input  fifo_dout, fifo_dvalid, fifo_empty, fifo_full, fifo_count,
           loading, write_start, tx_start, overflow, bad_cmd, cmd
  );

  modport slave (
    input  rx_data, rx_valid, fifo_rd_en,
    output fifo_dout, fifo_dvalid, fifo_empty, fifo_full, fifo_count,
           loading, write_start, tx_start, overflow, bad_cmd, cmd
  );
endinterface

// File: rtl/uart_cmd_loader_sync_fifo.sv
// Synchronous byte FIFO with registered read data, drop-when-full and flush.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               clears pointers/count; overrides push and pop
//   push, push_data     write request and byte
//   pop                 read request (ignored when empty)
//   dout, dvalid        popped byte and its one-cycle valid strobe
//   empty, full, count  occupancy status
//   drop                combinational: a push is being discarded because full
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic [7:0]      push_data,
  input  logic            pop,
  output logic [7:0]      dout,
  output logic            dvalid,
  output logic            empty,
  output logic            full,
  output logic [ADDR_W:0] count,
  output logic            drop
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic              do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    // Fullness is judged before any same-cycle pop, so a push into a full
    // FIFO is lost even when a pop frees a slot on the same edge.
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    drop     = push && full && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dvalid_d = do_pop;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dout_d   = mem_q[rd_ptr_q];
      end
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign count  = count_q;

endmodule

// File: rtl/uart_cmd_loader.sv
// Host command decoder sitting behind the UART receiver. Decodes command
// bytes, buffers payload in a sync_fifo for the pixel-config shifter and
// issues single-cycle write/tx start strobes.
// Ports:
//   CLK    system clock
//   Reset  synchronous active-low reset
//   bus    uart_cmd_loader_if.slave: rx byte stream, FIFO read side, status
//
// state | meaning
// IDLE  | waiting for a command byte (FF load, 7F write, 7E tx)
// LOAD  | bytes are payload pushed to the FIFO until FE arrives
module uart_cmd_loader
  import uart_cmd_loader_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                CLK,
  input  logic                Reset,
  uart_cmd_loader_if.slave    bus
);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic       write_start_q, write_start_d;
  logic       tx_start_q, tx_start_d;
  logic       bad_cmd_q, bad_cmd_d;
  logic       overflow_q, overflow_d;

  logic       fifo_flush;
  logic       fifo_push;
  logic       fifo_drop;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (Reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (bus.rx_data),
    .pop       (bus.fifo_rd_en),
    .dout      (bus.fifo_dout),
    .dvalid    (bus.fifo_dvalid),
    .empty     (bus.fifo_empty),
    .full      (bus.fifo_full),
    .count     (bus.fifo_count),
    .drop      (fifo_drop)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    write_start_d = 1'b0;
    tx_start_d    = 1'b0;
    bad_cmd_d     = 1'b0;
    overflow_d    = overflow_q;
    fifo_flush    = 1'b0;
    fifo_push     = 1'b0;

    if (bus.rx_valid) begin
      unique case (state_q)
        IDLE: begin
          unique case (bus.rx_data)
            CMD_LOAD: begin
              fifo_flush = 1'b1;
              overflow_d = 1'b0;
              state_d    = LOAD;
              cmd_d      = CMD_LOAD;
            end
            CMD_WRITE: begin
              write_start_d = 1'b1;
              cmd_d         = CMD_WRITE;
            end
            CMD_TX: begin
              tx_start_d = 1'b1;
              cmd_d      = CMD_TX;
            end
            // FE outside a load is also unexpected.
            default: bad_cmd_d = 1'b1;
          endcase
        end
        LOAD: begin
          if (bus.rx_data == CMD_END) begin
            state_d = IDLE;
            cmd_d   = CMD_END;
          end else begin
            fifo_push = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (fifo_drop) overflow_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q       <= IDLE;
      cmd_q         <= 8'h00;
      write_start_q <= 1'b0;
      tx_start_q    <= 1'b0;
      bad_cmd_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      write_start_q <= write_start_d;
      tx_start_q    <= tx_start_d;
      bad_cmd_q     <= bad_cmd_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.loading     = (state_q == LOAD);
  assign bus.cmd         = cmd_q;
  assign bus.write_start = write_start_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.bad_cmd     = bad_cmd_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_uart_cmd_loader.sv
module tb_uart_cmd_loader;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic CLK;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_cmd_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_cmd_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: payload queue plus the few visible registers.
  logic [7:0] m_q[$];
  bit         m_load, m_ovf, m_ws, m_tx, m_bad, m_dvalid;
  logic [7:0] m_cmd, m_dout;

  function automatic void model_reset();
    m_q.delete();
    m_load = 0; m_ovf = 0; m_ws = 0; m_tx = 0; m_bad = 0; m_dvalid = 0;
    m_cmd = 8'h00; m_dout = 8'h00;
  endfunction

  function automatic void model_step(input bit rv, input logic [7:0] d, input bit rd);
    int  old_size;
    bit  flush, pushing;
    old_size = m_q.size();
    flush = 0; pushing = 0;
    m_ws = 0; m_tx = 0; m_bad = 0; m_dvalid = 0;
    if (rv) begin
      if (!m_load) begin
        if (d == 8'hFF) begin
          flush = 1; m_q.delete(); m_ovf = 0; m_load = 1; m_cmd = d;
        end else if (d == 8'h7F) begin
          m_ws = 1; m_cmd = d;
        end else if (d == 8'h7E) begin
          m_tx = 1; m_cmd = d;
        end else begin
          m_bad = 1;
        end
      end else if (d == 8'hFE) begin
        m_load = 0; m_cmd = d;
      end else begin
        pushing = 1;
      end
    end
    if (rd && old_size > 0 && !flush) begin
      m_dout = m_q.pop_front();
      m_dvalid = 1;
    end
    if (pushing) begin
      if (old_size == DEPTH) m_ovf = 1;
      else m_q.push_back(d);
    end
  endfunction

  task automatic cyc(input bit rv, input logic [7:0] d, input bit rd);
    bus.rx_valid   = rv;
    bus.rx_data    = d;
    bus.fifo_rd_en = rd;
    model_step(rv, d, rd);
    @(negedge CLK);
    bus.rx_valid   = 1'b0;
    bus.fifo_rd_en = 1'b0;
  endtask

  task automatic reset_dut(input int n);
    Reset = 1'b0;
    model_reset();
    repeat (n) @(negedge CLK);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut(2);
    n_checks++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b want 1", bus.fifo_empty); end
    n_checks++; if (bus.fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
    n_checks++; if (bus.loading !== 1'b0) begin n_fail++; $display("FAIL reset_loading got %0b want 0", bus.loading); end
    n_checks++; if (bus.cmd !== 8'h00) begin n_fail++; $display("FAIL reset_cmd got %h want 00", bus.cmd); end
    n_checks++; if (bus.fifo_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", bus.fifo_dout); end
    n_checks++;
    if ({bus.write_start, bus.tx_start, bus.bad_cmd, bus.fifo_dvalid, bus.overflow, bus.fifo_full} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 000000",
        {bus.write_start, bus.tx_start, bus.bad_cmd, bus.fifo_dvalid, bus.overflow, bus.fifo_full});
    end
  endtask

  task automatic test_load_pop();
    logic [7:0] pay [3];
    pay[0] = 8'h55; pay[1] = 8'h01; pay[2] = 8'hB1;
    cyc(1, 8'hFF, 0);
    n_checks++; if (bus.loading !== 1'b1) begin n_fail++; $display("FAIL load_enter got %0b want 1", bus.loading); end
    for (int i = 0; i < 3; i++) cyc(1, pay[i], 0);
    cyc(1, 8'hFE, 0);
    n_checks++; if (bus.loading !== 1'b0) begin n_fail++; $display("FAIL load_exit got %0b want 0", bus.loading); end
    n_checks++; if (bus.fifo_count !== 5'd3) begin n_fail++; $display("FAIL load_count got %0d want 3", bus.fifo_count); end
    n_checks++; if (bus.cmd !== 8'hFE) begin n_fail++; $display("FAIL load_cmd got %h want FE", bus.cmd); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'h00, 1);
      n_checks++;
      if (bus.fifo_dvalid !== 1'b1 || bus.fifo_dout !== pay[i]) begin
        n_fail++; $display("FAIL load_pop%0d got dv=%0b dout=%h want dv=1 dout=%h", i, bus.fifo_dvalid, bus.fifo_dout, pay[i]);
      end
    end
    cyc(0, 8'h00, 0);
    n_checks++; if (bus.fifo_empty !== 1'b1 || bus.fifo_dvalid !== 1'b0) begin
      n_fail++; $display("FAIL load_drained got empty=%0b dv=%0b want 1 0", bus.fifo_empty, bus.fifo_dvalid); end
  endtask

  task automatic test_write_tx();
    cyc(1, 8'h7F, 0);
    n_checks++; if ({bus.write_start, bus.tx_start} !== 2'b10 || bus.cmd !== 8'h7F) begin
      n_fail++; $display("FAIL write_strobe got ws/tx=%b cmd=%h want 10 7F", {bus.write_start, bus.tx_start}, bus.cmd); end
    cyc(1, 8'h7E, 0);
    n_checks++; if ({bus.write_start, bus.tx_start} !== 2'b01 || bus.cmd !== 8'h7E) begin
      n_fail++; $display("FAIL tx_strobe got ws/tx=%b cmd=%h want 01 7E", {bus.write_start, bus.tx_start}, bus.cmd); end
    cyc(0, 8'h00, 0);
    n_checks++; if ({bus.write_start, bus.tx_start} !== 2'b00 || bus.fifo_count !== 5'd0 || bus.loading !== 1'b0) begin
      n_fail++; $display("FAIL strobe_clear got ws/tx=%b count=%0d load=%0b want 00 0 0",
        {bus.write_start, bus.tx_start}, bus.fifo_count, bus.loading); end
  endtask

  task automatic test_overflow();
    cyc(1, 8'hFF, 0);
    for (int i = 0; i < DEPTH + 2; i++) cyc(1, 8'(i), 0);
    n_checks++; if (bus.fifo_full !== 1'b1 || bus.fifo_count !== 5'd16 || bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_state got full=%0b count=%0d ovf=%0b want 1 16 1", bus.fifo_full, bus.fifo_count, bus.overflow); end
    cyc(1, 8'hFE, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 8'h00, 1);
      n_checks++; if (bus.fifo_dvalid !== 1'b1 || bus.fifo_dout !== 8'(i)) begin
        n_fail++; $display("FAIL ovf_pop%0d got dv=%0b dout=%h want 1 %h", i, bus.fifo_dvalid, bus.fifo_dout, 8'(i)); end
    end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b want 1", bus.overflow); end
    cyc(1, 8'hFF, 0);
    n_checks++; if (bus.overflow !== 1'b0 || bus.fifo_count !== 5'd0) begin
      n_fail++; $display("FAIL ovf_flush got ovf=%0b count=%0d want 0 0", bus.overflow, bus.fifo_count); end
    cyc(1, 8'hFE, 0);
  endtask

  task automatic test_full_push_pop();
    cyc(1, 8'hFF, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'hA0 + 8'(i), 0);
    cyc(1, 8'hCC, 1);
    n_checks++; if (bus.fifo_count !== 5'd15 || bus.fifo_dvalid !== 1'b1 || bus.fifo_dout !== 8'hA0 || bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL fullpp got count=%0d dv=%0b dout=%h ovf=%0b want 15 1 A0 1",
        bus.fifo_count, bus.fifo_dvalid, bus.fifo_dout, bus.overflow); end
    cyc(1, 8'hFE, 0);
    for (int i = 1; i < DEPTH; i++) begin
      cyc(0, 8'h00, 1);
      n_checks++; if (bus.fifo_dout !== 8'hA0 + 8'(i)) begin
        n_fail++; $display("FAIL fullpp_pop%0d got %h want %h", i, bus.fifo_dout, 8'hA0 + 8'(i)); end
    end
    n_checks++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL fullpp_empty got %0b want 1", bus.fifo_empty); end
  endtask

  task automatic test_reset_mid_load();
    cyc(1, 8'hFF, 0);
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
    reset_dut(1);
    n_checks++; if (bus.loading !== 1'b0 || bus.fifo_count !== 5'd0 || bus.fifo_empty !== 1'b1 || bus.cmd !== 8'h00 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL midreset got load=%0b count=%0d empty=%0b cmd=%h ovf=%0b want 0 0 1 00 0",
        bus.loading, bus.fifo_count, bus.fifo_empty, bus.cmd, bus.overflow); end
    cyc(1, 8'hAA, 0);
    n_checks++; if (bus.bad_cmd !== 1'b1 || bus.fifo_count !== 5'd0) begin
      n_fail++; $display("FAIL midreset_aa got bad=%0b count=%0d want 1 0", bus.bad_cmd, bus.fifo_count); end
  endtask

  task automatic test_bad_cmd();
    cyc(1, 8'h7E, 0);
    cyc(1, 8'h12, 0);
    n_checks++; if (bus.bad_cmd !== 1'b1 || bus.cmd !== 8'h7E || bus.tx_start !== 1'b0) begin
      n_fail++; $display("FAIL bad_12 got bad=%0b cmd=%h tx=%0b want 1 7E 0", bus.bad_cmd, bus.cmd, bus.tx_start); end
    cyc(1, 8'hFE, 0);
    n_checks++; if (bus.bad_cmd !== 1'b1 || bus.cmd !== 8'h7E) begin
      n_fail++; $display("FAIL bad_fe got bad=%0b cmd=%h want 1 7E", bus.bad_cmd, bus.cmd); end
    cyc(0, 8'h00, 1);
    n_checks++; if (bus.bad_cmd !== 1'b0 || bus.fifo_dvalid !== 1'b0) begin
      n_fail++; $display("FAIL empty_pop got bad=%0b dv=%0b want 0 0", bus.bad_cmd, bus.fifo_dvalid); end
  endtask

  task automatic test_random();
    bit         rv, rd;
    logic [7:0] d;
    int         sel;
    reset_dut(1);
    for (int n = 0; n < 1500; n++) begin
      rv  = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 19);
      if (sel == 0)      d = 8'hFF;
      else if (sel == 1) d = 8'hFE;
      else if (sel == 2) d = 8'h7F;
      else if (sel == 3) d = 8'h7E;
      else               d = 8'($urandom);
      rd = ($urandom_range(0, 3) == 0);
      // Keep pops away from the flush cycle so every step has one clear outcome.
      if (rv && !m_load && d == 8'hFF) rd = 0;
      cyc(rv, d, rd);
      n_checks++;
      if ({bus.loading, bus.write_start, bus.tx_start, bus.bad_cmd, bus.overflow, bus.fifo_dvalid}
          !== {m_load, m_ws, m_tx, m_bad, m_ovf, m_dvalid}) begin
        n_fail++; $display("FAIL rnd_flags@%0d got %b want %b", n,
          {bus.loading, bus.write_start, bus.tx_start, bus.bad_cmd, bus.overflow, bus.fifo_dvalid},
          {m_load, m_ws, m_tx, m_bad, m_ovf, m_dvalid});
      end
      n_checks++;
      if (bus.fifo_count !== 5'(m_q.size()) || bus.fifo_empty !== (m_q.size() == 0) || bus.fifo_full !== (m_q.size() == DEPTH)) begin
        n_fail++; $display("FAIL rnd_count@%0d got %0d e=%0b f=%0b want %0d", n,
          bus.fifo_count, bus.fifo_empty, bus.fifo_full, m_q.size());
      end
      n_checks++;
      if (bus.cmd !== m_cmd || bus.fifo_dout !== m_dout) begin
        n_fail++; $display("FAIL rnd_data@%0d got cmd=%h dout=%h want cmd=%h dout=%h", n,
          bus.cmd, bus.fifo_dout, m_cmd, m_dout);
      end
    end
  endtask

  initial begin
    Reset          = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'h00;
    bus.fifo_rd_en = 1'b0;
    model_reset();
    @(negedge CLK);
    test_reset();
    test_load_pop();
    test_write_tx();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_load();
    test_bad_cmd();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
